scan_chain_loader: RTL and testbench

// - Bit-serial driver for a chain of scff scan cells: parallel config words in, shifted into the chain head (SI).
// - Simultaneously captures bits falling out of the chain tail and re-packs them into parallel readback words.
// - Sits between the config/debug bus and the fabric scan chain; one pass = exactly CHAIN_LEN shifts.

---
 rtl/scan_chain_loader.sv | 164 ++++++++++++++++
 tb/tb_scan_chain_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_loader.sv
// rtl/scan_chain_loader.sv - bit-serial scan chain writer with simultaneous readback capture
// Optional feature: define SCAN_READBACK_CRC_EN to add a CRC-8 (poly 0x07) port over captured bits.
module scan_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              scan_en,
  output logic              scan_si,
  input  logic              scan_so,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done
`ifdef SCAN_READBACK_CRC_EN
  ,
  output logic [7:0]        crc
`endif
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int WB = $clog2(WORD_W + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(CHAIN_LEN - 1);
  localparam logic [WB-1:0] LAST_WBIT = WB'(WORD_W - 1);

  generate
    if ((CHAIN_LEN <= 0) || (CHAIN_LEN % WORD_W != 0)) begin : g_bad_len
      $error("scan_chain_loader: CHAIN_LEN must be a positive multiple of WORD_W");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [WORD_W-1:0]   cap_q, cap_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [WB-1:0]       wbit_q, wbit_d;
  logic [WORD_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                stall;
  logic [WORD_W:0]     cap_ext;
  logic [WORD_W-1:0]   cap_next;
`ifdef SCAN_READBACK_CRC_EN
  logic [7:0]          crc_q, crc_d;
  logic                crc_fb;
`endif

  // A pending readback word that the consumer is not taking freezes the chain,
  // so no captured bit can be overwritten.
  assign stall    = rd_valid_q && !rd_ready;
  // Tail bit enters at the MSB so the first captured bit ends up at bit 0.
  assign cap_ext  = {~scan_so, cap_q};
  assign cap_next = cap_ext[WORD_W:1];

  // Next-state and handshake/strobe decode for the pass sequencer.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cap_d      = cap_q;
    bit_d      = bit_q;
    wbit_d     = wbit_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    wr_ready   = 1'b0;
    scan_en    = 1'b0;
`ifdef SCAN_READBACK_CRC_EN
    crc_d      = crc_q;
    crc_fb     = crc_q[7] ^ ~scan_so;
`endif

    if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          bit_d   = '0;
          wbit_d  = '0;
`ifdef SCAN_READBACK_CRC_EN
          crc_d   = 8'h00;
`endif
        end
      end
      S_FETCH: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          shreg_d = wr_data;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!stall) begin
          scan_en = 1'b1;
          shreg_d = shreg_q >> 1;
          cap_d   = cap_next;
          bit_d   = bit_q + 1'b1;
`ifdef SCAN_READBACK_CRC_EN
          crc_d   = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
`endif
          if (wbit_q == LAST_WBIT) begin
            wbit_d     = '0;
            rd_data_d  = cap_next;
            rd_valid_d = 1'b1;
            state_d    = (bit_q == LAST_BIT) ? S_DONE : S_FETCH;
          end else begin
            wbit_d = wbit_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset forces IDLE so scan_en drops at once.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      cap_q      <= '0;
      bit_q      <= '0;
      wbit_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef SCAN_READBACK_CRC_EN
      crc_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cap_q      <= cap_d;
      bit_q      <= bit_d;
      wbit_q     <= wbit_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifdef SCAN_READBACK_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign scan_si  = shreg_q[0];
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
`ifdef SCAN_READBACK_CRC_EN
  assign crc      = crc_q;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// tb/tb_scan_chain_loader.sv - randomized self-checking bench for scan_chain_loader
module tb_scan_chain_loader;

  localparam int CL = 16;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          R = 1'b1;
  logic          start = 1'b0;
  logic [WW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          scan_en;
  logic          scan_si;
  logic          scan_so;
  logic [WW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b1;
  logic          busy;
  logic          done;
`ifdef SCAN_READBACK_CRC_EN
  logic [7:0]    crc;
`endif

  scan_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk      (clk),
    .R        (R),
    .start    (start),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .scan_en  (scan_en),
    .scan_si  (scan_si),
    .scan_so  (scan_so),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .busy     (busy),
    .done     (done)
`ifdef SCAN_READBACK_CRC_EN
    ,.crc     (crc)
`endif
  );

  always #5 clk = ~clk;

  // Fabric: chain of scff cells, Q cleared at power-up, tail SO = ~Q.
  logic [CL-1:0] chain_q = '0;
  assign scan_so = ~chain_q[CL-1];

  int        shift_cnt = 0;
  int        busy_cyc  = 0;
  int        done_cnt  = 0;
  logic [7:0] rd_q[$];

  // Chain cells and event counters, all evaluated on the DUT clock edge.
  always @(posedge clk) begin
    if (scan_en) begin
      chain_q   <= {chain_q[CL-2:0], scan_si};
      shift_cnt <= shift_cnt + 1;
    end
    if (busy) busy_cyc <= busy_cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (rd_valid && rd_ready) rd_q.push_back(rd_data);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the chain is a CL-deep FIFO of bits; readback = what falls out.
  bit mq[$];

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic [7:0] n;
    n = {c[6:0], 1'b0};
    if (c[7] ^ b) n = n ^ 8'h07;
    return n;
  endfunction

  task automatic model_pass(input logic [7:0] w0, input logic [7:0] w1,
                            output logic [7:0] e0, output logic [7:0] e1,
                            output logic [7:0] ec);
    logic [15:0] win;
    logic [15:0] outb;
    win = {w1, w0};
    outb = '0;
    ec = 8'h00;
    for (int i = 0; i < CL; i++) begin
      bit b;
      b = mq.pop_front();
      outb[i] = b;
      ec = crc_step(ec, b);
      mq.push_back(win[i]);
    end
    e0 = outb[7:0];
    e1 = outb[15:8];
  endtask

  task automatic send(input logic [7:0] w, input int dly);
    int n;
    n = 0;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) chk("wr_ready_timeout", 32'd0, 32'd1);
    for (int i = 0; i < dly; i++) begin
      chk("gap_scan_en", {31'd0, scan_en}, 32'd0);
      @(negedge clk);
    end
    wr_data  = w;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic run_pass(input logic [7:0] w0, input logic [7:0] w1,
                          input int gap, input int hold, input bit poke);
    logic [7:0] e0, e1, ec;
    int bs, bb, bd, n;
    model_pass(w0, w1, e0, e1, ec);
    rd_q.delete();
    rd_ready = (hold == 0);
    bs = shift_cnt;
    bb = busy_cyc;
    bd = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    fork
      begin
        send(w0, 0);
        if (poke) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
        send(w1, gap);
      end
      begin
        if (hold > 0) begin
          repeat (hold) @(negedge clk);
          chk("stall_shifts", shift_cnt - bs, 32'd8);
          chk("stall_rd_valid", {31'd0, rd_valid}, 32'd1);
          rd_ready = 1'b1;
        end
      end
    join
    n = 0;
    while (done_cnt == bd && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, done_cnt != bd}, 32'd1);
    repeat (3) @(negedge clk);
    chk("pass_shifts", shift_cnt - bs, CL);
    chk("done_pulses", done_cnt - bd, 32'd1);
    chk("busy_end", {31'd0, busy}, 32'd0);
    if (hold == 0) chk("busy_cycles", busy_cyc - bb, 19 + gap);
    chk("rd_count", rd_q.size(), 32'd2);
    if (rd_q.size() == 2) begin
      chk("rd_word0", {24'd0, rd_q[0]}, {24'd0, e0});
      chk("rd_word1", {24'd0, rd_q[1]}, {24'd0, e1});
    end
`ifdef SCAN_READBACK_CRC_EN
    chk("crc", {24'd0, crc}, {24'd0, ec});
`endif
  endtask

  task automatic run_abort(input logic [7:0] w);
    int bs, n;
    rd_q.delete();
    rd_ready = 1'b1;
    bs = shift_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(w, 0);
    n = 0;
    while (shift_cnt - bs < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_shifts", shift_cnt - bs, 32'd5);
    R = 1'b1;
    #1;
    chk("abort_scan_en", {31'd0, scan_en}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("abort_wr_ready", {31'd0, wr_ready}, 32'd0);
    @(negedge clk);
    R = 1'b0;
    for (int i = 0; i < 5; i++) begin
      void'(mq.pop_front());
      mq.push_back(w[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < CL; i++) mq.push_back(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_scan_en", {31'd0, scan_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_scan_si", {31'd0, scan_si}, 32'd0);
`ifdef SCAN_READBACK_CRC_EN
    chk("rst_crc", {24'd0, crc}, 32'd0);
`endif
    R = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_pass(8'hA5, 8'h3C, 0, 0, 1'b0);
    run_pass(8'h00, 8'h00, 0, 0, 1'b0);
    run_pass(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 5, 0, 1'b0);
    run_pass(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 24, 1'b0);
    run_pass(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1, 0, 1'b1);
    run_abort(8'($urandom_range(0, 255)));
    run_pass(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_pass(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) ? 24 : 0,
               1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
